// File: rtl/axil_sys_if_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_sys_if_pkg
// Brief    : Shared types and constants for the AXI4-Lite to sys_if bridge.
// Revision : 1.0 - initial release
// ============================================================================
package axil_sys_if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_EXEC = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_RESP = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] FULL_STRB   = 4'hF;

    // Register file is word addressed; byte offset bits are dropped.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_sys_if_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_sys_if_bridge_if
// Brief    : AXI4-Lite slave channels plus the sys_if register bus.
// Revision : 1.0 - initial release
// ============================================================================
interface axil_sys_if_bridge_if #(
    parameter int AXI_ADDR_WIDTH = 12
);
    logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr;
    logic                      s_axil_awvalid;
    logic                      s_axil_awready;
    logic [31:0]               s_axil_wdata;
    logic [3:0]                s_axil_wstrb;
    logic                      s_axil_wvalid;
    logic                      s_axil_wready;
    logic [1:0]                s_axil_bresp;
    logic                      s_axil_bvalid;
    logic                      s_axil_bready;
    logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr;
    logic                      s_axil_arvalid;
    logic                      s_axil_arready;
    logic [31:0]               s_axil_rdata;
    logic [1:0]                s_axil_rresp;
    logic                      s_axil_rvalid;
    logic                      s_axil_rready;
    logic                      sys_if_wen;
    logic [31:0]               sys_if_addr;
    logic [31:0]               sys_if_wdata;
    logic [31:0]               sys_if_rdata;

    modport slave (
        input  s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb,
               s_axil_wvalid, s_axil_bready, s_axil_araddr, s_axil_arvalid,
               s_axil_rready, sys_if_rdata,
        output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
               s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
               sys_if_wen, sys_if_addr, sys_if_wdata
    );

    modport master (
        output s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb,
               s_axil_wvalid, s_axil_bready, s_axil_araddr, s_axil_arvalid,
               s_axil_rready, sys_if_rdata,
        input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
               s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
               sys_if_wen, sys_if_addr, sys_if_wdata
    );
endinterface
`default_nettype wire

// File: rtl/axil_sys_if_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axil_sys_if_bridge
// Brief    : AXI4-Lite slave serialising host accesses onto the sys_if bus.
// Revision : 1.0 - initial release
// ============================================================================
module axil_sys_if_bridge
    import axil_sys_if_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int RD_WAIT        = 1
) (
    input logic                 sys_if_clk,
    input logic                 sys_if_rst,
    axil_sys_if_bridge_if.slave bus
);

    localparam logic [3:0] C_WAIT_LOAD = 4'(RD_WAIT - 1);

    state_e      state_q, state_d;
    logic        last_was_write_q, last_was_write_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        wen_q, wen_d;
    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;

    logic w_idle;
    logic w_wr_req;
    logic w_rd_req;
    logic w_grant_wr;
    logic w_grant_rd;

    // Write needs both AW and W present; on contention the flag alternates.
    always_comb begin
        w_idle     = (state_q == ST_IDLE);
        w_wr_req   = bus.s_axil_awvalid && bus.s_axil_wvalid;
        w_rd_req   = bus.s_axil_arvalid;
        w_grant_wr = w_idle && w_wr_req && (!w_rd_req || !last_was_write_q);
        w_grant_rd = w_idle && w_rd_req && (!w_wr_req || last_was_write_q);
    end

    always_comb begin
        state_d          = state_q;
        last_was_write_d = last_was_write_q;
        wait_cnt_d       = wait_cnt_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        bresp_d          = bresp_q;
        wen_d            = 1'b0;
        bvalid_d         = bvalid_q;
        rvalid_d         = rvalid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (w_grant_wr) begin
                    state_d          = ST_WR_EXEC;
                    last_was_write_d = 1'b1;
                    addr_d           = word_addr(32'(bus.s_axil_awaddr[AXI_ADDR_WIDTH-1:0]));
                    wdata_d          = bus.s_axil_wdata;
                    wen_d            = (bus.s_axil_wstrb == FULL_STRB);
                    bresp_d          = (bus.s_axil_wstrb == FULL_STRB) ? RESP_OKAY : RESP_SLVERR;
                end else if (w_grant_rd) begin
                    state_d          = ST_RD_WAIT;
                    last_was_write_d = 1'b0;
                    addr_d           = word_addr(32'(bus.s_axil_araddr[AXI_ADDR_WIDTH-1:0]));
                    wait_cnt_d       = C_WAIT_LOAD;
                end
            end
            ST_WR_EXEC: begin
                bvalid_d = 1'b1;
                state_d  = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (bus.s_axil_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    rdata_d  = bus.sys_if_rdata;
                    rvalid_d = 1'b1;
                    state_d  = ST_RD_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RD_RESP: begin
                if (bus.s_axil_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_if_clk or posedge sys_if_rst) begin
        if (sys_if_rst) begin
            state_q          <= ST_IDLE;
            last_was_write_q <= 1'b0;
            wait_cnt_q       <= 4'd0;
            addr_q           <= 32'd0;
            wdata_q          <= 32'd0;
            rdata_q          <= 32'd0;
            bresp_q          <= RESP_OKAY;
            wen_q            <= 1'b0;
            bvalid_q         <= 1'b0;
            rvalid_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_was_write_q <= last_was_write_d;
            wait_cnt_q       <= wait_cnt_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            rdata_q          <= rdata_d;
            bresp_q          <= bresp_d;
            wen_q            <= wen_d;
            bvalid_q         <= bvalid_d;
            rvalid_q         <= rvalid_d;
        end
    end

    assign bus.s_axil_awready = w_grant_wr;
    assign bus.s_axil_wready  = w_grant_wr;
    assign bus.s_axil_arready = w_grant_rd;
    assign bus.s_axil_bresp   = bresp_q;
    assign bus.s_axil_bvalid  = bvalid_q;
    assign bus.s_axil_rdata   = rdata_q;
    assign bus.s_axil_rresp   = RESP_OKAY;
    assign bus.s_axil_rvalid  = rvalid_q;
    assign bus.sys_if_wen     = wen_q;
    assign bus.sys_if_addr    = addr_q;
    assign bus.sys_if_wdata   = wdata_q;

endmodule
`default_nettype wire
